// File: rtl/fpu_pkg.sv
// Shared float32 constants, FSM state encoding and operand class for fpu-side blocks.
// Pure declarations; no logic, no latency.
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Exponent at which the 24-bit significand is already an integer (unit in LSB).
    localparam logic [7:0] EXP_UNITY = 8'(EXP_BIAS + MANT_W);
    // Smallest exponent whose magnitude is at least 2^31.
    localparam logic [7:0] EXP_SAT   = 8'(EXP_BIAS + 31);
    // Beyond 25 right shifts every significand bit already lives in sticky.
    localparam logic [4:0] RSHIFT_MAX = 5'd25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_SHIFT,
        ST_ROUND,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // -2^31 is the only value with |A| >= 2^31 that still fits in int32.
    function automatic logic is_int_min(input logic sign, input logic [7:0] exp,
                                        input logic [22:0] frac);
        return sign && (exp == EXP_SAT) && (frac == '0);
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational float32 field splitter and classifier (zero/denormal, normal, inf, NaN).
// Zero latency; no handshake, output follows the operand.
module fp_unpack
    import fpu_pkg::*;
(
    input  logic [31:0] a_i,
    output logic        sign_o,
    output logic [7:0]  exp_o,
    output logic [22:0] frac_o,
    output logic        hidden_o,
    output logic [1:0]  cls_o
);

    always_comb begin
        sign_o   = a_i[31];
        exp_o    = a_i[30:23];
        frac_o   = a_i[22:0];
        hidden_o = |a_i[30:23];
        if (a_i[30:23] == 8'hFF) begin
            cls_o = (a_i[22:0] != '0) ? FP_NAN : FP_INF;
        end else if (a_i[30:23] == 8'h00) begin
            cls_o = FP_ZERO;
        end else begin
            cls_o = FP_NORMAL;
        end
    end

endmodule

// File: rtl/fp_to_int.sv
// float32 -> int32 round-to-nearest-even, one shift per cycle; done 1 edge after accept for
// specials, 2+n otherwise (max 27). start is ignored while busy; a start in DONE restarts at once.
module fp_to_int
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    output logic [31:0] R,
    output logic        done,
    output logic        overflow,
    output logic        invalid
);

    logic        u_sign;
    logic [7:0]  u_exp;
    logic [22:0] u_frac;
    logic        u_hidden;
    logic [1:0]  u_cls;

    fp_unpack u_unpack (
        .a_i      (A),
        .sign_o   (u_sign),
        .exp_o    (u_exp),
        .frac_o   (u_frac),
        .hidden_o (u_hidden),
        .cls_o    (u_cls)
    );

    state_e      state_q,  state_d;
    fp_class_e   cls_q,    cls_d;
    logic        sign_q,   sign_d;
    logic [7:0]  exp_q,    exp_d;
    logic [31:0] mag_q,    mag_d;
    logic        guard_q,  guard_d;
    logic        sticky_q, sticky_d;
    logic        left_q,   left_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [31:0] r_q,      r_d;
    logic        done_q,   done_d;
    logic        ovf_q,    ovf_d;
    logic        inv_q,    inv_d;

    logic [7:0]  exp_diff;
    logic        round_up;
    logic [31:0] mag_rnd;

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mag_d    = mag_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        left_d   = left_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;

        exp_diff = (exp_q > EXP_UNITY) ? (exp_q - EXP_UNITY) : (EXP_UNITY - exp_q);
        round_up = guard_q & (sticky_q | mag_q[0]);
        mag_rnd  = mag_q + {31'b0, round_up};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_UNPACK;
                    cls_d    = fp_class_e'(u_cls);
                    sign_d   = u_sign;
                    exp_d    = u_exp;
                    mag_d    = {8'b0, u_hidden, u_frac};
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    done_d   = 1'b0;
                    ovf_d    = 1'b0;
                    inv_d    = 1'b0;
                end
            end
            ST_UNPACK: begin
                if (cls_q == FP_NAN) begin
                    state_d = ST_DONE;
                    r_d     = INT_MIN;
                    inv_d   = 1'b1;
                    done_d  = 1'b1;
                end else if (cls_q == FP_INF || exp_q >= EXP_SAT) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (is_int_min(sign_q, exp_q, mag_q[22:0])) begin
                        r_d = INT_MIN;
                    end else begin
                        r_d   = sign_q ? INT_MIN : INT_MAX;
                        ovf_d = 1'b1;
                    end
                end else if (exp_q == EXP_UNITY) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_SHIFT;
                    left_d  = (exp_q > EXP_UNITY);
                    // Left counts never exceed 7, so only right shifts hit the clamp.
                    cnt_d   = (exp_diff > {3'b0, RSHIFT_MAX}) ? RSHIFT_MAX : exp_diff[4:0];
                end
            end
            ST_SHIFT: begin
                if (left_q) begin
                    mag_d = {mag_q[30:0], 1'b0};
                end else begin
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
                    mag_d    = {1'b0, mag_q[31:1]};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                // exp <= 157 keeps mag_rnd below 2^31, so no saturation here.
                mag_d   = mag_rnd;
                r_d     = sign_q ? (32'd0 - mag_rnd) : mag_rnd;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cls_q    <= FP_ZERO;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mag_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            left_q   <= 1'b0;
            cnt_q    <= '0;
            r_q      <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mag_q    <= mag_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            left_q   <= left_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
        end
    end

    assign R        = r_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign invalid  = inv_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: directed corner cases plus random operands
// against an integer-arithmetic reference of float32 -> int32 RNE conversion.
module tb_fp_to_int;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] R;
    logic        done;
    logic        overflow;
    logic        invalid;

    int n_vec;
    int n_err;

    fp_to_int dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .R        (R),
        .done     (done),
        .overflow (overflow),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: value = sig * 2^(e-150), rounded to nearest even, then range-checked.
    task automatic ref_model(input logic [31:0] a, output logic [31:0] r,
                             output logic ovf, output logic inv, output int lat);
        logic        s;
        int          e;
        longint      sig, q, rem, half, val;
        int          sh;
        s   = a[31];
        e   = int'(a[30:23]);
        sig = longint'(a[22:0]) + ((e != 0) ? 64'sd8388608 : 64'sd0);
        ovf = 1'b0;
        inv = 1'b0;
        lat = 1;
        if (e == 255) begin
            if (a[22:0] != 0) begin
                r   = 32'h8000_0000;
                inv = 1'b1;
            end else begin
                r   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                ovf = 1'b1;
            end
        end else if (e >= 158) begin
            // magnitude >= 2^31: representable only as exactly -2^31
            if (s && e == 158 && a[22:0] == 0) begin
                r = 32'h8000_0000;
            end else begin
                r   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                ovf = 1'b1;
            end
        end else begin
            sh = e - 150;
            if (sh >= 0) begin
                q   = sig <<< sh;
                lat = 2 + sh;
            end else begin
                lat = 2 + ((-sh > 25) ? 25 : -sh);
                if (-sh > 40) begin
                    q = 0;
                end else begin
                    q    = sig >>> (-sh);
                    rem  = sig - (q <<< (-sh));
                    half = 64'sd1 <<< (-sh - 1);
                    if (rem > half || (rem == half && q[0])) q = q + 1;
                end
            end
            val = s ? -q : q;
            r   = val[31:0];
        end
    endtask

    task automatic launch(input logic [31:0] a);
        @(negedge clk);
        A     = a;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] er,
                           input logic eo, input logic ei, input int el);
        int lat;
        launch(a);
        chk({tag, "/done_low"}, {31'b0, done}, 32'd0);
        lat = 0;
        wait_done(lat);
        chk({tag, "/latency"}, lat, el);
        chk({tag, "/R"}, R, er);
        chk({tag, "/overflow"}, {31'b0, overflow}, {31'b0, eo});
        chk({tag, "/invalid"}, {31'b0, invalid}, {31'b0, ei});
    endtask

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] r;
        logic        o;
        logic        i;
        int          lat;
    } dvec_t;

    dvec_t dir_tbl[$];

    initial begin
        logic [31:0] er;
        logic        eo, ei;
        int          el;
        int          lat;
        logic [31:0] a;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;

        #1;
        chk("reset/R", R, 32'd0);
        chk("reset/done", {31'b0, done}, 32'd0);
        chk("reset/overflow", {31'b0, overflow}, 32'd0);
        chk("reset/invalid", {31'b0, invalid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        dir_tbl = '{
            '{"pi",      32'h4049_0FDB, 32'h0000_0003, 1'b0, 1'b0, 24},
            '{"half",    32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 26},
            '{"1p5",     32'h3FC0_0000, 32'h0000_0002, 1'b0, 1'b0, 25},
            '{"2p5",     32'h4020_0000, 32'h0000_0002, 1'b0, 1'b0, 24},
            '{"m2p5",    32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 24},
            '{"0p75",    32'h3F40_0000, 32'h0000_0001, 1'b0, 1'b0, 26},
            '{"maxflt",  32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9},
            '{"2p31",    32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1},
            '{"m2p31",   32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1},
            '{"nan",     32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 1},
            '{"ninf",    32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1},
            '{"denorm",  32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 27},
            '{"negzero", 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 27},
            '{"p150",    32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 2}
        };
        foreach (dir_tbl[k]) begin
            run_vec(dir_tbl[k].tag, dir_tbl[k].a, dir_tbl[k].r,
                    dir_tbl[k].o, dir_tbl[k].i, dir_tbl[k].lat);
        end

        // start while busy must not disturb the conversion in flight
        launch(32'h4049_0FDB);
        lat = 0;
        @(negedge clk); lat++;
        @(negedge clk); lat++;
        A     = 32'h4120_0000;
        start = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0;
        wait_done(lat);
        chk("busy/latency", lat, 24);
        chk("busy/R", R, 32'h0000_0003);

        // async reset in the middle of SHIFT
        launch(32'h4049_0FDB);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst/R", R, 32'd0);
        chk("midrst/done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("after_rst", 32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 22);

        // back-to-back start issued while sitting in DONE
        run_vec("b2b", 32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 19);

        for (int k = 0; k < 250; k++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       a = a;
                1:       a[30:23] = (($urandom_range(0, 1)) != 0) ? 8'hFF : 8'h00;
                default: a[30:23] = 8'($urandom_range(110, 160));
            endcase
            ref_model(a, er, eo, ei, el);
            run_vec($sformatf("rnd%0d_%h", k, a), a, er, eo, ei, el);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
